// File: rtl/round_timer.sv
// round_timer: countdown round timer with two-digit BCD seconds display.
// A round is loaded from a binary seconds value (saturated to 99), counts down
// once per TICKS_PER_SEC tick pulses, can be paused with hold, and signals
// expiry with a level (expired) and a single-cycle pulse (timeout).
module round_timer #(
  parameter int TICKS_PER_SEC = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       hold,
  input  logic       clear,
  input  logic [6:0] time_limit,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       expired,
  output logic       timeout,
  output logic       warn
);

  localparam int SUB_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [SUB_W-1:0] sub;
  logic [SUB_W-1:0] sub_nxt;
  logic [3:0]       tens_nxt;
  logic [3:0]       ones_nxt;
  logic             timeout_nxt;
  logic [7:0]       load_bcd;
  logic             load_zero;
  logic [7:0]       dec_bcd;
  logic             take_start;

  // Binary seconds to two BCD digits, saturating anything above 99.
  function automatic logic [7:0] sat_bcd(input logic [6:0] bin);
    logic [6:0] v;
    logic [3:0] t;
    logic [3:0] o;
    v = (bin > 7'd99) ? 7'd99 : bin;
    t = 4'(v / 7'd10);
    o = 4'(v % 7'd10);
    return {t, o};
  endfunction

  // Two-digit BCD decrement with borrow; floors at 00 so digits stay in 0..9.
  function automatic logic [7:0] bcd_dec(input logic [3:0] t, input logic [3:0] o);
    if (o != 4'd0) begin
      return {t, o - 4'd1};
    end else if (t != 4'd0) begin
      return {t - 4'd1, 4'd9};
    end else begin
      return 8'h00;
    end
  endfunction

  assign load_bcd   = sat_bcd(time_limit);
  assign load_zero  = (load_bcd == 8'h00);
  assign dec_bcd    = bcd_dec(sec_tens, sec_ones);
  // start is honoured everywhere except while paused
  assign take_start = start && (state != PAUSE);

  // Next-state and next-datapath selection; clear outranks start, start outranks hold and tick.
  always_comb begin
    state_nxt   = state;
    sub_nxt     = sub;
    tens_nxt    = sec_tens;
    ones_nxt    = sec_ones;
    timeout_nxt = 1'b0;

    if (clear) begin
      state_nxt = IDLE;
      sub_nxt   = '0;
      tens_nxt  = 4'd0;
      ones_nxt  = 4'd0;
    end else if (take_start) begin
      {tens_nxt, ones_nxt} = load_bcd;
      sub_nxt              = '0;
      state_nxt            = load_zero ? EXPIRED : RUN;
      timeout_nxt          = load_zero;
    end else begin
      case (state)
        RUN: begin
          if (hold) begin
            // the tick in this cycle is dropped; sub and digits carry over
            state_nxt = PAUSE;
          end else if (tick) begin
            if (sub < SUB_LAST) begin
              sub_nxt = sub + SUB_W'(1);
            end else begin
              sub_nxt              = '0;
              {tens_nxt, ones_nxt} = dec_bcd;
              if (dec_bcd == 8'h00) begin
                state_nxt   = EXPIRED;
                timeout_nxt = 1'b1;
              end
            end
          end
        end
        PAUSE: begin
          if (!hold) begin
            state_nxt = RUN;
          end
        end
        default: begin
          // IDLE and EXPIRED only react to start/clear, handled above
          state_nxt = state;
        end
      endcase
    end
  end

  // State, sub-counter, digits and all status outputs are registered together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      sub      <= '0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
      running  <= 1'b0;
      expired  <= 1'b0;
      timeout  <= 1'b0;
      warn     <= 1'b0;
    end else begin
      state    <= state_nxt;
      sub      <= sub_nxt;
      sec_tens <= tens_nxt;
      sec_ones <= ones_nxt;
      running  <= (state_nxt == RUN);
      expired  <= (state_nxt == EXPIRED);
      timeout  <= timeout_nxt;
      warn     <= ((state_nxt == RUN) || (state_nxt == PAUSE)) && (tens_nxt == 4'd0);
    end
  end

endmodule

// File: tb/tb_round_timer.sv
// tb_round_timer: directed scenarios plus randomized traffic for round_timer,
// checked every cycle against a seconds-and-ticks reference model.
module tb_round_timer;

  localparam int TPS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       hold = 1'b0;
  logic       clear = 1'b0;
  logic [6:0] time_limit = 7'd0;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       expired;
  logic       timeout;
  logic       warn;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: what the round is doing, seconds left, ticks into this second
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int m_mode = M_IDLE;
  int m_rem  = 0;
  int m_tc   = 0;
  bit m_to   = 1'b0;

  round_timer #(.TICKS_PER_SEC(TPS)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .start      (start),
    .hold       (hold),
    .clear      (clear),
    .time_limit (time_limit),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .running    (running),
    .expired    (expired),
    .timeout    (timeout),
    .warn       (warn)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [11:0] obs_vec();
    return {sec_tens, sec_ones, running, expired, timeout, warn};
  endfunction

  function automatic logic [11:0] exp_vec();
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(m_rem / 10);
    o = 4'(m_rem % 10);
    return {t, o, (m_mode == M_RUN), (m_mode == M_DONE), m_to,
            ((m_mode == M_RUN) || (m_mode == M_PAUSE)) && (m_rem < 10)};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_rem  = 0;
    m_tc   = 0;
    m_to   = 1'b0;
  endtask

  task automatic model_load(input int tl);
    m_rem = (tl > 99) ? 99 : tl;
    m_tc  = 0;
    if (m_rem == 0) begin
      m_mode = M_DONE;
      m_to   = 1'b1;
    end else begin
      m_mode = M_RUN;
    end
  endtask

  task automatic model_step(input bit s, input bit h, input bit c, input bit t, input int tl);
    m_to = 1'b0;
    if (c) begin
      model_reset();
    end else if (s && m_mode != M_PAUSE) begin
      model_load(tl);
    end else if (m_mode == M_RUN) begin
      if (h) begin
        m_mode = M_PAUSE;
      end else if (t) begin
        m_tc++;
        if (m_tc == TPS) begin
          m_tc = 0;
          m_rem--;
          if (m_rem == 0) begin
            m_mode = M_DONE;
            m_to   = 1'b1;
          end
        end
      end
    end else if (m_mode == M_PAUSE && !h) begin
      m_mode = M_RUN;
    end
  endtask

  // one clock: drive inputs, let the edge happen, advance model, compare
  task automatic step(input string tag, input bit s, input bit h, input bit c, input bit t, input int tl);
    start = s;
    hold = h;
    clear = c;
    tick = t;
    time_limit = 7'(tl);
    @(posedge clk);
    model_step(s, h, c, t, tl);
    #1;
    check(tag, obs_vec(), exp_vec());
  endtask

  initial begin
    // power-on reset, asserted without any clock edge
    #1 rst = 1'b0;
    #2;
    check("reset_outputs", {20'd0, obs_vec()}, 32'd0);
    model_reset();
    #9 rst = 1'b1;

    step("idle_wait", 0, 0, 0, 1, 0);

    // three-second round with a tick every cycle
    step("r31_start", 1, 0, 0, 0, 3);
    check("r31_load", {sec_tens, sec_ones}, 8'h03);
    for (int i = 1; i <= 12; i++) begin
      step("r31_run", 0, 0, 0, 1, 0);
      if (i == 4) check("r31_two", {sec_tens, sec_ones}, 8'h02);
      if (i < 12) check("r31_warn", warn, 1'b1);
    end
    check("r31_timeout", {sec_tens, sec_ones, timeout, expired}, {8'h00, 1'b1, 1'b1});
    step("r31_after", 0, 0, 0, 1, 0);
    check("r31_pulse_once", {timeout, expired}, 2'b01);

    // hold freezes countdown, resume keeps the partial second
    step("r32_start", 1, 0, 0, 0, 12);
    for (int i = 0; i < 8; i++) step("r32_run", 0, 0, 0, 1, 0);
    check("r32_ten", {sec_tens, sec_ones, warn}, {8'h10, 1'b0});
    for (int i = 0; i < 20; i++) step("r32_hold", 0, 1, 0, 1, 0);
    check("r32_frozen", {sec_tens, sec_ones, running}, {8'h10, 1'b0});
    step("r32_release", 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step("r32_resume", 0, 0, 0, 1, 0);
    check("r32_not_yet", {sec_tens, sec_ones, warn}, {8'h10, 1'b0});
    step("r32_resume", 0, 0, 0, 1, 0);
    check("r32_nine", {sec_tens, sec_ones, warn}, {8'h09, 1'b1});

    // saturation and zero-length round
    step("r33_sat", 1, 0, 0, 1, 120);
    check("r33_99", {sec_tens, sec_ones}, 8'h99);
    step("r33_zero", 1, 0, 0, 1, 0);
    check("r33_zero_exp", {sec_tens, sec_ones, expired, timeout}, {8'h00, 1'b1, 1'b1});

    // clear beats start; start alone restarts the sub-second count
    step("r34_start", 1, 0, 0, 0, 50);
    for (int i = 0; i < 5; i++) step("r34_run", 0, 0, 0, 1, 0);
    step("r34_clear", 1, 0, 1, 1, 30);
    check("r34_cleared", {sec_tens, sec_ones, running, timeout}, {8'h00, 1'b0, 1'b0});
    step("r34_go", 1, 0, 0, 0, 20);
    for (int i = 0; i < 6; i++) step("r34_run", 0, 0, 0, 1, 0);
    check("r34_mid", {sec_tens, sec_ones}, 8'h19);
    step("r34_restart", 1, 0, 0, 1, 20);
    for (int i = 0; i < 3; i++) step("r34_run", 0, 0, 0, 1, 0);
    check("r34_sub_reset", {sec_tens, sec_ones}, 8'h20);
    step("r34_run", 0, 0, 0, 1, 0);
    check("r34_dec", {sec_tens, sec_ones}, 8'h19);

    // asynchronous reset between clock edges
    step("r35_start", 1, 0, 0, 0, 30);
    for (int i = 0; i < 5; i++) step("r35_run", 0, 0, 0, 1, 0);
    #2 rst = 1'b0;
    #1;
    check("r35_async", {20'd0, obs_vec()}, 32'd0);
    model_reset();
    #2 rst = 1'b1;
    step("r35_idle", 0, 0, 0, 1, 0);
    step("r35_fresh", 1, 0, 0, 0, 5);
    check("r35_loaded", {sec_tens, sec_ones, running}, {8'h05, 1'b1});

    // randomized traffic
    begin
      bit h;
      h = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        bit s;
        bit c;
        bit t;
        int tl;
        s = ($urandom_range(0, 15) == 0);
        c = ($urandom_range(0, 40) == 0);
        t = ($urandom_range(0, 1) == 1);
        if ($urandom_range(0, 7) == 0) h = ~h;
        tl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 12));
        step("random", s, h, c, t, tl);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
